// File: rtl/lemming_dig_scheduler.sv
// Dig-permit scheduler for a crew of lemming walkers: latches dig requests, grants
// tokens round-robin to lemmings walking on ground, and flags splats on overlong falls.
module lemming_dig_scheduler #(
  parameter int N          = 4,
  parameter int DIG_TOKENS = 3,
  parameter int MAX_FALL   = 20
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] dig_req_i,
  input  logic [N-1:0] walking_i,
  input  logic [N-1:0] falling_i,
  input  logic [N-1:0] ground_i,
  input  logic         refill_i,
  output logic [N-1:0] dig_o,
  output logic [N-1:0] splat_o,
  output logic [3:0]   tokens_o,
  output logic         grant_valid_o,
  output logic [2:0]   grant_idx_o
);

  localparam int FW = $clog2(MAX_FALL + 2);
  localparam logic [FW-1:0] FSAT  = FW'(MAX_FALL + 1);
  localparam logic [FW-1:0] FSAFE = FW'(MAX_FALL);

  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] dig_q, dig_d;
  logic [N-1:0] splat_q, splat_d;
  logic [3:0]   tokens_q, tokens_d;
  logic [2:0]   ptr_q, ptr_d;
  logic         grant_valid_q;
  logic [2:0]   grant_idx_q;

  logic [N-1:0] elig;
  logic [7:0]   elig_ext;
  logic [7:0]   grant_ext;
  logic [2:0]   cand [N];
  logic [N-1:0] hit;
  logic [N-1:0] sel;
  logic [N:0]   seen;
  logic [2:0]   win_acc [N+1];
  logic         any_grant;
  logic [2:0]   win;
  logic [3:0]   win_plus1;

  assign elig = pend_q & walking_i & ground_i & ~splat_q & ~dig_q
              & {N{tokens_q != 4'd0}};

  always_comb begin
    elig_ext        = '0;
    elig_ext[N-1:0] = elig;
  end

  assign seen[0]    = 1'b0;
  assign win_acc[0] = 3'd0;

  // Slot gi of the search examines lemming (ptr + gi) mod N; first hit wins.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lemming
      logic [3:0]    sum;
      logic [FW-1:0] fcnt_q;

      assign sum             = {1'b0, ptr_q} + 4'(gi);
      assign cand[gi]        = (sum >= 4'(N)) ? 3'(sum - 4'(N)) : sum[2:0];
      assign hit[gi]         = elig_ext[cand[gi]];
      assign sel[gi]         = hit[gi] & ~seen[gi];
      assign seen[gi+1]      = seen[gi] | hit[gi];
      assign win_acc[gi+1]   = win_acc[gi] | ({3{sel[gi]}} & cand[gi]);

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          fcnt_q <= '0;
        end else if (falling_i[gi]) begin
          fcnt_q <= (fcnt_q == FSAT) ? fcnt_q : fcnt_q + FW'(1);
        end else begin
          fcnt_q <= '0;
        end
      end

      // The verdict is taken on the first non-falling cycle, from the saturated count.
      assign splat_d[gi] = splat_q[gi] | (~falling_i[gi] & (fcnt_q > FSAFE));
    end
  endgenerate

  assign any_grant = seen[N];
  assign win       = win_acc[N];
  assign grant_ext = any_grant ? (8'd1 << win) : 8'd0;
  assign dig_d     = grant_ext[N-1:0];
  assign win_plus1 = {1'b0, win} + 4'd1;

  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) begin
      ptr_d = (win_plus1 == 4'(N)) ? 3'd0 : win_plus1[2:0];
    end
  end

  // Refill overrides the decrement of a simultaneous grant.
  always_comb begin
    tokens_d = tokens_q;
    if (refill_i) begin
      tokens_d = 4'(DIG_TOKENS);
    end else if (any_grant) begin
      tokens_d = tokens_q - 4'd1;
    end
  end

  // A grant clears the pending bit even if a fresh request arrives in the same cycle.
  assign pend_d = (pend_q | dig_req_i) & ~dig_d & ~splat_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q        <= '0;
      dig_q         <= '0;
      splat_q       <= '0;
      tokens_q      <= 4'(DIG_TOKENS);
      ptr_q         <= 3'd0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= 3'd0;
    end else begin
      pend_q        <= pend_d;
      dig_q         <= dig_d;
      splat_q       <= splat_d;
      tokens_q      <= tokens_d;
      ptr_q         <= ptr_d;
      grant_valid_q <= any_grant;
      grant_idx_q   <= any_grant ? win : 3'd0;
    end
  end

  assign dig_o         = dig_q;
  assign splat_o       = splat_q;
  assign tokens_o      = tokens_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_idx_o   = grant_idx_q;

endmodule

// File: tb/tb_lemming_dig_scheduler.sv
module tb_lemming_dig_scheduler;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [3:0] dig_req_i = '0;
    logic [3:0] walking_i = 4'hF;
    logic [3:0] falling_i = '0;
    logic [3:0] ground_i = 4'hF;
    logic       refill_i = 1'b0;
    logic [3:0] dig_o;
    logic [3:0] splat_o;
    logic [3:0] tokens_o;
    logic       grant_valid_o;
    logic [2:0] grant_idx_o;

    always #5 clk_i = ~clk_i;

    lemming_dig_scheduler #(.N(4), .DIG_TOKENS(3), .MAX_FALL(20)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .dig_req_i     (dig_req_i),
        .walking_i     (walking_i),
        .falling_i     (falling_i),
        .ground_i      (ground_i),
        .refill_i      (refill_i),
        .dig_o         (dig_o),
        .splat_o       (splat_o),
        .tokens_o      (tokens_o),
        .grant_valid_o (grant_valid_o),
        .grant_idx_o   (grant_idx_o)
    );

    typedef struct packed {
        logic       rst;
        logic       refill;
        logic [3:0] req;
        logic [3:0] walk;
        logic [3:0] gnd;
        logic [3:0] fall;
    } in_t;

    typedef struct packed {
        logic [3:0] dig;
        logic [3:0] tok;
        logic [3:0] splat;
        logic       gv;
        logic [2:0] gidx;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } row_t;

    row_t vec_tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    logic done = 1'b0;

    function automatic void add(input logic r, input logic f, input logic [3:0] req,
                                input logic [3:0] walk, input logic [3:0] gnd,
                                input logic [3:0] fall, input logic [3:0] dig,
                                input logic [3:0] tok, input logic [3:0] spl,
                                input logic gv, input logic [2:0] gi);
        row_t x;
        x.i = '{rst: r, refill: f, req: req, walk: walk, gnd: gnd, fall: fall};
        x.e = '{dig: dig, tok: tok, splat: spl, gv: gv, gidx: gi};
        vec_tbl.push_back(x);
    endfunction

    function automatic void idle(input logic [3:0] tok, input logic [3:0] spl);
        add(0, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, tok, spl, 0, 3'd0);
    endfunction

    initial begin
        repeat (2000) @(posedge clk_i);
        if (!done) begin
            $display("FAIL timeout: bench did not complete within 2000 cycles");
            $finish;
        end
    end

    initial begin
        exp_t got, want;

        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (dig_o === 4'h0 && splat_o === 4'h0 && tokens_o === 4'd3 &&
            grant_valid_o === 1'b0 && grant_idx_o === 3'd0) begin
            passed++;
            $display("PASS reset state: dig=%b tokens=%0d splat=%b gv=%b gidx=%0d",
                     dig_o, tokens_o, splat_o, grant_valid_o, grant_idx_o);
        end else begin
            $display("FAIL reset state: dig=%b tokens=%0d splat=%b gv=%b gidx=%0d",
                     dig_o, tokens_o, splat_o, grant_valid_o, grant_idx_o);
        end

        add(1, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        idle(4'd3, 4'h0);
        add(0, 0, 4'h4, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        add(0, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h4, 4'd2, 4'h0, 1, 3'd2);
        idle(4'd2, 4'h0);
        idle(4'd2, 4'h0);

        add(1, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        add(0, 0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        add(0, 0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h1, 4'd2, 4'h0, 1, 3'd0);
        add(0, 0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h2, 4'd1, 4'h0, 1, 3'd1);
        add(0, 0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h4, 4'd0, 4'h0, 1, 3'd2);
        idle(4'd0, 4'h0);
        idle(4'd0, 4'h0);
        add(0, 1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        add(0, 1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h8, 4'd3, 4'h0, 1, 3'd3);
        add(0, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h1, 4'd2, 4'h0, 1, 3'd0);
        add(0, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h2, 4'd1, 4'h0, 1, 3'd1);
        idle(4'd1, 4'h0);
        add(0, 1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);

        add(0, 0, 4'h2, 4'hD, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        for (int k = 0; k < 4; k++)
            add(0, 0, 4'h0, 4'hD, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        add(0, 0, 4'h0, 4'hF, 4'hD, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        add(0, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h2, 4'd2, 4'h0, 1, 3'd1);
        idle(4'd2, 4'h0);

        add(0, 0, 4'h4, 4'hF, 4'hF, 4'h0, 4'h0, 4'd2, 4'h0, 0, 3'd0);
        add(0, 0, 4'h4, 4'hF, 4'hF, 4'h0, 4'h4, 4'd1, 4'h0, 1, 3'd2);
        idle(4'd1, 4'h0);
        idle(4'd1, 4'h0);
        add(0, 1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);

        for (int k = 0; k < 20; k++)
            add(0, 0, 4'h0, 4'hE, 4'hF, 4'h1, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        idle(4'd3, 4'h0);
        idle(4'd3, 4'h0);

        for (int k = 0; k < 21; k++)
            add(0, 0, 4'h0, 4'hD, 4'hF, 4'h2, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        idle(4'd3, 4'h2);
        add(0, 0, 4'h2, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h2, 0, 3'd0);
        for (int k = 0; k < 3; k++)
            idle(4'd3, 4'h2);

        add(0, 0, 4'h1, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h2, 0, 3'd0);
        add(1, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        add(0, 0, 4'h9, 4'hF, 4'hF, 4'h0, 4'h0, 4'd3, 4'h0, 0, 3'd0);
        add(0, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h1, 4'd2, 4'h0, 1, 3'd0);
        add(0, 0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h8, 4'd1, 4'h0, 1, 3'd3);
        idle(4'd1, 4'h0);

        for (int r = 0; r < vec_tbl.size(); r++) begin
            reset_i   = vec_tbl[r].i.rst;
            refill_i  = vec_tbl[r].i.refill;
            dig_req_i = vec_tbl[r].i.req;
            walking_i = vec_tbl[r].i.walk;
            ground_i  = vec_tbl[r].i.gnd;
            falling_i = vec_tbl[r].i.fall;
            sb.push_back(vec_tbl[r].e);
            @(posedge clk_i);
            #1;
            got  = '{dig: dig_o, tok: tokens_o, splat: splat_o, gv: grant_valid_o, gidx: grant_idx_o};
            want = sb.pop_front();
            checks++;
            if (got === want) begin
                passed++;
                $display("PASS row %0d: dig=%b tokens=%0d splat=%b gv=%b gidx=%0d",
                         r, got.dig, got.tok, got.splat, got.gv, got.gidx);
            end else begin
                $display("FAIL row %0d: dig=%b tokens=%0d splat=%b gv=%b gidx=%0d, expected dig=%b tokens=%0d splat=%b gv=%b gidx=%0d",
                         r, got.dig, got.tok, got.splat, got.gv, got.gidx,
                         want.dig, want.tok, want.splat, want.gv, want.gidx);
            end
        end

        done = 1'b1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
